spi_reg_writer: RTL and testbench

Downstream of the SPI byte receiver: consumes its byte/strobe stream and turns SPI frames into SID register writes. Each frame is parsed as command + data bytes, supporting single writes and auto-incrementing bursts. The resulting {address, data} pairs are buffered in a small show-ahead FIFO. The FIFO drains to the SID register file over a valid/ready handshake.

---
 rtl/spi_reg_writer.sv | 134 +++++++++++++
 tb/tb_spi_reg_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// Turns SPI frames (command byte + data bytes) into SID register writes,
// buffered in a small show-ahead FIFO drained over a valid/ready handshake.
module spi_reg_writer #(
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    spi_data_i,
  input  logic          spi_recv_i,
  input  logic          spi_cs_i,
  output logic          wr_valid_o,
  output logic [4:0]    wr_addr_o,
  output logic [7:0]    wr_data_o,
  input  logic          wr_ready_i,
  output logic [LW-1:0] level_o,
  output logic          ovf_o,
  output logic          bad_cmd_o,
  input  logic          stat_clr_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_CMD, S_DATA, S_BURST, S_SKIP} state_t;

  state_t        state_q, state_d;
  logic          cs_s1_q, cs_n_q;
  logic [4:0]    addr_q, addr_d;
  logic [12:0]   mem_q [FIFO_DEPTH];
  logic [12:0]   head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q, bad_q;
  logic          accept, push, set_bad, pop, full, do_write, set_ovf;
  logic [12:0]   wentry;

  assign accept = spi_recv_i & ~cs_n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_s1_q <= 1'b1;
      cs_n_q  <= 1'b1;
      state_q <= S_CMD;
      addr_q  <= '0;
    end else begin
      cs_s1_q <= spi_cs_i;
      cs_n_q  <= cs_s1_q;
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    set_bad = 1'b0;
    if (cs_n_q) begin
      state_d = S_CMD;
    end else if (accept) begin
      unique case (state_q)
        S_CMD: begin
          if (!spi_data_i[7]) begin
            state_d = S_SKIP;
          end else if (spi_data_i[5]) begin
            state_d = S_SKIP;
            set_bad = 1'b1;
          end else begin
            addr_d  = spi_data_i[4:0];
            state_d = spi_data_i[6] ? S_BURST : S_DATA;
          end
        end
        S_DATA: begin
          push    = 1'b1;
          state_d = S_CMD;
        end
        S_BURST: begin
          push   = 1'b1;
          addr_d = addr_q + 5'd1;
        end
        default: state_d = S_SKIP;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wentry   = {addr_q, spi_data_i};
  assign pop      = (count_q != '0) & wr_ready_i;
  assign full     = (count_q == LW'(FIFO_DEPTH));
  assign do_write = push & (~full | pop);
  assign set_ovf  = push & full & ~pop;

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_write && !pop)      count_d = count_q + LW'(1);
    else if (!do_write && pop) count_d = count_q - LW'(1);
    head_d = head_q;
    if (count_d != '0) begin
      if (do_write && (wr_ptr_q == rd_ptr_d)) head_d = wentry;
      else                                    head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= wentry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (do_write) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= set_ovf | (ovf_q & ~stat_clr_i);
      bad_q    <= set_bad | (bad_q & ~stat_clr_i);
    end
  end

  assign wr_valid_o = (count_q != '0);
  assign wr_addr_o  = head_q[12:8];
  assign wr_data_o  = head_q[7:0];
  assign level_o    = count_q;
  assign ovf_o      = ovf_q;
  assign bad_cmd_o  = bad_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: single/burst writes, overflow, bad commands, reset.
module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_data = 8'h00;
  logic       spi_recv = 1'b0;
  logic       spi_cs = 1'b1;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready = 1'b0;
  logic [2:0] level;
  logic       ovf, bad_cmd;
  logic       stat_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [12:0] got [$];

  spi_reg_writer #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .spi_data_i(spi_data), .spi_recv_i(spi_recv),
    .spi_cs_i(spi_cs), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .level_o(level), .ovf_o(ovf), .bad_cmd_o(bad_cmd),
    .stat_clr_i(stat_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && wr_valid && wr_ready) got.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data = b;
    spi_recv = 1'b1;
    tick();
    spi_recv = 1'b0;
  endtask

  task automatic select();
    spi_cs = 1'b0;
    tick();
    tick();
  endtask

  task automatic deselect();
    spi_cs = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic check_got(input string tag, input int idx, input logic [12:0] exp);
    if (idx < got.size()) check(tag, 32'(got[idx]), 32'(exp));
    else check(tag, 32'h1_0000, 32'(exp));
  endtask

  initial begin
    #3;
    check("rst_valid", 32'(wr_valid), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_bad", 32'(bad_cmd), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single write, then a second command in the same frame
    wr_ready = 1'b1;
    got.delete();
    select();
    send_byte(8'h85);
    check("sw_novalid_after_cmd", 32'(wr_valid), 0);
    send_byte(8'h3C);
    check("sw_valid", 32'(wr_valid), 1);
    check("sw_addr", 32'(wr_addr), 32'h05);
    check("sw_data", 32'(wr_data), 32'h3C);
    tick();
    check("sw_one_cycle", 32'(wr_valid), 0);
    check("sw_count", 32'(got.size()), 1);
    send_byte(8'h83);
    send_byte(8'h44);
    tick();
    check("sw_second_cmd_count", 32'(got.size()), 2);
    check_got("sw_second_cmd", 1, {5'h03, 8'h44});
    deselect();

    // burst with address wrap
    got.delete();
    select();
    send_byte(8'hDE);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    tick();
    deselect();
    check("burst_count", 32'(got.size()), 3);
    check_got("burst_w0", 0, {5'h1E, 8'h11});
    check_got("burst_w1", 1, {5'h1F, 8'h22});
    check_got("burst_w2", 2, {5'h00, 8'h33});

    // overflow: 6 bytes into a 4-deep FIFO with consumer stalled
    wr_ready = 1'b0;
    select();
    send_byte(8'hC0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    check("ovf_level", 32'(level), 4);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_head", 32'({wr_addr, wr_data}), 32'({5'h00, 8'hA0}));
    deselect();
    got.delete();
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("ovf_drain_count", 32'(got.size()), 4);
    check_got("ovf_drain0", 0, {5'h00, 8'hA0});
    check_got("ovf_drain3", 3, {5'h03, 8'hA3});
    check("ovf_drained_level", 32'(level), 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);

    // full FIFO with simultaneous push and pop
    wr_ready = 1'b0;
    select();
    send_byte(8'hC8);
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
    check("pp_full_level", 32'(level), 4);
    wr_ready = 1'b1;
    send_byte(8'hB4);
    wr_ready = 1'b0;
    check("pp_level", 32'(level), 4);
    check("pp_ovf", 32'(ovf), 0);
    check("pp_head", 32'({wr_addr, wr_data}), 32'({5'h09, 8'hB1}));
    deselect();
    got.delete();
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pp_drain_count", 32'(got.size()), 4);
    check_got("pp_drain_last", 3, {5'h0C, 8'hB4});

    // bad and no-op commands
    got.delete();
    select();
    send_byte(8'hA3);
    send_byte(8'h55);
    tick();
    check("bad_flag", 32'(bad_cmd), 1);
    check("bad_nowrite", 32'(got.size()), 0);
    deselect();
    select();
    send_byte(8'h03);
    send_byte(8'h55);
    tick();
    check("noop_nowrite", 32'(got.size()), 0);
    check("noop_bad_unchanged", 32'(bad_cmd), 1);
    deselect();
    select();
    stat_clr = 1'b1;
    send_byte(8'hA3);
    stat_clr = 1'b0;
    check("bad_set_wins", 32'(bad_cmd), 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("bad_cleared", 32'(bad_cmd), 0);
    deselect();

    // command abandoned by deselect
    got.delete();
    select();
    send_byte(8'h85);
    deselect();
    select();
    send_byte(8'h86);
    send_byte(8'h77);
    tick();
    deselect();
    check("desel_count", 32'(got.size()), 1);
    check_got("desel_write", 0, {5'h06, 8'h77});

    // asynchronous reset mid-burst
    wr_ready = 1'b0;
    select();
    send_byte(8'hC4);
    send_byte(8'h01);
    send_byte(8'h02);
    check("mid_level", 32'(level), 2);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(wr_valid), 0);
    check("arst_addr", 32'(wr_addr), 0);
    check("arst_data", 32'(wr_data), 0);
    check("arst_level", 32'(level), 0);
    spi_cs = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    got.delete();
    wr_ready = 1'b1;
    select();
    send_byte(8'h81);
    send_byte(8'h5A);
    tick();
    check("post_rst_count", 32'(got.size()), 1);
    check_got("post_rst_write", 0, {5'h01, 8'h5A});
    deselect();

    // strobes while deselected are ignored
    got.delete();
    send_byte(8'h85);
    send_byte(8'h99);
    send_byte(8'hC0);
    send_byte(8'h12);
    tick();
    check("desel_strobe_level", 32'(level), 0);
    check("desel_strobe_nowrite", 32'(got.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
